// File: rtl/ram_arbiter_pkg.sv
// Shared bus widths and address-decode helper for the two-master RAM arbiter.
package ram_arbiter_pkg;

  localparam int unsigned ADDR_BUS = 32;
  localparam int unsigned DATA_BUS = 32;
  localparam int unsigned SEL_BUS  = 4;

  // Bad when any bit above the RAM window is set or the address is not word aligned.
  function automatic logic addr_bad(input logic [ADDR_BUS-1:0] addr,
                                    input int unsigned        ram_bits);
    return ((addr >> ram_bits) != '0) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the last-grant register moves only on an accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  logic r_last;  // 1 = master 1 was granted last

  assign o_gnt[1] = i_req[1] & (~i_req[0] | ~r_last);
  assign o_gnt[0] = i_req[0] & ~o_gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (i_accept && (i_req != 2'b00)) begin
      r_last <= o_gnt[1];
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates two request/ack masters onto a single-port RAM with bounded-latency responses.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 9
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [SEL_BUS-1:0]  m0_sel,
  input  logic [ADDR_BUS-1:0] m0_addr,
  input  logic [DATA_BUS-1:0] m0_wdata,
  output logic                m0_ack,
  output logic                m0_err,
  output logic [DATA_BUS-1:0] m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [SEL_BUS-1:0]  m1_sel,
  input  logic [ADDR_BUS-1:0] m1_addr,
  input  logic [DATA_BUS-1:0] m1_wdata,
  output logic                m1_ack,
  output logic                m1_err,
  output logic [DATA_BUS-1:0] m1_rdata,
  output logic                ram_en,
  output logic                ram_write_en,
  output logic [SEL_BUS-1:0]  ram_write_sel,
  output logic [ADDR_BUS-1:0] ram_addr,
  output logic [DATA_BUS-1:0] ram_data_in,
  input  logic [DATA_BUS-1:0] ram_data_out
);

  typedef enum logic [2:0] {StIdle, StRead, StWrite, StWhold, StResp} state_e;

  state_e              r_state;
  logic                r_gnt1, r_we, r_err;
  logic [SEL_BUS-1:0]  r_sel;
  logic [ADDR_BUS-1:0] r_addr;
  logic [DATA_BUS-1:0] r_wdata, r_rdata;
  logic                r_ram_en, r_ram_we;
  logic [SEL_BUS-1:0]  r_ram_sel;
  logic                r_m0_ack, r_m1_ack, r_m0_err, r_m1_err;
  logic [DATA_BUS-1:0] r_m0_rdata, r_m1_rdata;

  logic [1:0]          w_req, w_gnt;
  logic                w_accept, w_we, w_bad;
  logic [SEL_BUS-1:0]  w_sel;
  logic [ADDR_BUS-1:0] w_addr;
  logic [DATA_BUS-1:0] w_wdata;

  // A master whose ack is showing still holds its old request this cycle; mask it.
  assign w_req    = {m1_req & ~r_m1_ack, m0_req & ~r_m0_ack};
  assign w_accept = (r_state == StIdle) && (w_req != 2'b00);

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (rst),
    .i_req    (w_req),
    .i_accept (w_accept),
    .o_gnt    (w_gnt)
  );

  assign w_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_sel   = w_gnt[1] ? m1_sel   : m0_sel;
  assign w_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign w_bad   = addr_bad(w_addr, RAM_ADDR_BITS);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_gnt1     <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_sel      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ram_en   <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_sel  <= '0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_gnt1  <= w_gnt[1];
            r_we    <= w_we;
            r_sel   <= w_sel;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= w_bad;
            r_rdata <= '0;
            if (w_bad) begin
              r_state <= StResp;
            end else if (w_we) begin
              r_state   <= StWrite;
              r_ram_en  <= 1'b1;
              r_ram_we  <= 1'b1;
              r_ram_sel <= w_sel;
            end else begin
              r_state  <= StRead;
              r_ram_en <= 1'b1;
            end
          end
        end
        StRead: begin
          r_rdata  <= ram_data_out;
          r_ram_en <= 1'b0;
          r_state  <= StResp;
        end
        StWrite: begin
          r_ram_en <= 1'b0;
          r_ram_we <= 1'b0;
          r_state  <= StWhold;
        end
        StWhold: begin
          r_ram_sel <= '0;
          r_state   <= StResp;
        end
        StResp: begin
          if (r_gnt1) begin
            r_m1_ack   <= 1'b1;
            r_m1_err   <= r_err;
            r_m1_rdata <= r_we ? '0 : r_rdata;
          end else begin
            r_m0_ack   <= 1'b1;
            r_m0_err   <= r_err;
            r_m0_rdata <= r_we ? '0 : r_rdata;
          end
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign m0_ack        = r_m0_ack;
  assign m0_err        = r_m0_err;
  assign m0_rdata      = r_m0_rdata;
  assign m1_ack        = r_m1_ack;
  assign m1_err        = r_m1_err;
  assign m1_rdata      = r_m1_rdata;
  assign ram_en        = r_ram_en;
  assign ram_write_en  = r_ram_we;
  assign ram_write_sel = r_ram_sel;
  assign ram_addr      = r_addr;
  assign ram_data_in   = r_wdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural combinational-read RAM.
module tb_ram_arbiter;

  localparam int unsigned AW = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_sel, m1_sel;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_write_en;
  logic [3:0]  ram_write_sel;
  logic [31:0] ram_addr, ram_data_in, ram_data_out;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  logic [31:0] mem [0:127];
  logic        mem_loaded = 1'b0;

  always #5 clk = ~clk;

  ram_arbiter #(.RAM_ADDR_BITS(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .m0_req        (m0_req),
    .m0_we         (m0_we),
    .m0_sel        (m0_sel),
    .m0_addr       (m0_addr),
    .m0_wdata      (m0_wdata),
    .m0_ack        (m0_ack),
    .m0_err        (m0_err),
    .m0_rdata      (m0_rdata),
    .m1_req        (m1_req),
    .m1_we         (m1_we),
    .m1_sel        (m1_sel),
    .m1_addr       (m1_addr),
    .m1_wdata      (m1_wdata),
    .m1_ack        (m1_ack),
    .m1_err        (m1_err),
    .m1_rdata      (m1_rdata),
    .ram_en        (ram_en),
    .ram_write_en  (ram_write_en),
    .ram_write_sel (ram_write_sel),
    .ram_addr      (ram_addr),
    .ram_data_in   (ram_data_in),
    .ram_data_out  (ram_data_out)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, new_w, input logic [3:0] sel);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  assign ram_data_out = mem[ram_addr[AW-1:2]];

  // Memory is preloaded during the first reset only: word i = C0DE0000+i, word 8 = AABBCCDD.
  always @(posedge clk) begin
    if (rst && !mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hC0DE0000 + i;
      mem[8]     <= 32'hAABBCCDD;
      mem_loaded <= 1'b1;
    end else if (ram_en && ram_write_en) begin
      mem[ram_addr[AW-1:2]] <= merge(mem[ram_addr[AW-1:2]], ram_data_in, ram_write_sel);
    end
    if (ram_en) en_count <= en_count + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Raise a request at a negedge, count negedges until its ack, then drop the request.
  task automatic do_req(input bit m, input logic we, input logic [3:0] sel,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cyc);
    bit done;
    done  = 1'b0;
    cyc   = 0;
    rdata = '0;
    err   = 1'b0;
    @(negedge clk);
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata;
    end
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (m ? m1_ack : m0_ack) begin
        done  = 1'b1;
        rdata = m ? m1_rdata : m0_rdata;
        err   = m ? m1_err : m0_err;
        check("other_ack_low", {31'b0, (m ? m0_ack : m1_ack)}, 32'h0);
      end
    end
    if (m) m1_req = 1'b0;
    else   m0_req = 1'b0;
    check("ack_seen", {31'b0, done}, 32'h1);
  endtask

  logic [31:0] rd0, rd1;
  logic        er0, er1;
  int          cy0, cy1, en_before;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_sel = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_sel = 0; m1_addr = 0; m1_wdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_acks", {30'b0, m1_ack, m0_ack}, 32'h0);
    check("rst_errs", {30'b0, m1_err, m0_err}, 32'h0);
    check("rst_rdata", m0_rdata | m1_rdata, 32'h0);
    check("rst_ram_ctl", {26'b0, ram_en, ram_write_en, ram_write_sel}, 32'h0);
    check("rst_ram_addr", ram_addr, 32'h0);
    check("rst_ram_din", ram_data_in, 32'h0);
    rst = 1'b0;

    // Simultaneous reads after reset: m1 wins the first tie.
    fork
      do_req(1'b1, 1'b0, 4'h0, 32'h4, 32'h0, rd1, er1, cy1);
      do_req(1'b0, 1'b0, 4'h0, 32'h8, 32'h0, rd0, er0, cy0);
    join
    check("pairA_m1_lat", cy1, 3);
    check("pairA_m1_data", rd1, 32'hC0DE0001);
    check("pairA_m0_lat", cy0, 6);
    check("pairA_m0_data", rd0, 32'hC0DE0002);
    check("pairA_err", {30'b0, er1, er0}, 32'h0);

    // m1 full-word write; ack three cycles after grant with zero rdata.
    do_req(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd1, er1, cy1);
    check("wr_m1_lat", cy1, 4);
    check("wr_m1_rdata", rd1, 32'h0);
    check("wr_m1_err", {31'b0, er1}, 32'h0);

    // Second simultaneous pair: m1 was granted last, so m0 goes first.
    fork
      do_req(1'b0, 1'b0, 4'h0, 32'h10, 32'h0, rd0, er0, cy0);
      do_req(1'b1, 1'b0, 4'h0, 32'hC, 32'h0, rd1, er1, cy1);
    join
    check("pairB_m0_lat", cy0, 3);
    check("pairB_m0_data", rd0, 32'hDEADBEEF);
    check("pairB_m1_lat", cy1, 6);
    check("pairB_m1_data", rd1, 32'hC0DE0003);

    // Partial write onto AABBCCDD with the low two byte lanes enabled.
    do_req(1'b0, 1'b1, 4'b0011, 32'h20, 32'h11223344, rd0, er0, cy0);
    check("pw_lat", cy0, 4);
    do_req(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, rd0, er0, cy0);
    check("pw_readback", rd0, 32'hAABB3344);

    // Bad addresses: immediate error response and no RAM access.
    en_before = en_count;
    do_req(1'b1, 1'b0, 4'h0, 32'h202, 32'h0, rd1, er1, cy1);
    check("bad202_lat", cy1, 2);
    check("bad202_err", {31'b0, er1}, 32'h1);
    check("bad202_rdata", rd1, 32'h0);
    do_req(1'b1, 1'b0, 4'h0, 32'h200, 32'h0, rd1, er1, cy1);
    check("bad200_lat", cy1, 2);
    check("bad200_err", {31'b0, er1}, 32'h1);
    check("bad200_rdata", rd1, 32'h0);
    do_req(1'b0, 1'b1, 4'hF, 32'h102, 32'h12345678, rd0, er0, cy0);
    check("bad102_err", {31'b0, er0}, 32'h1);
    check("bad_no_ram_en", en_count - en_before, 0);

    // Reset while the write sits in WHOLD.
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b1; m0_sel = 4'hF; m0_addr = 32'h30; m0_wdata = 32'h12345678;
    @(negedge clk);
    check("wr_state_ctl", {30'b0, ram_en, ram_write_en}, 32'h3);
    check("wr_state_addr", ram_addr, 32'h30);
    @(negedge clk);
    check("whold_ctl", {30'b0, ram_en, ram_write_en}, 32'h0);
    check("whold_sel", {28'b0, ram_write_sel}, 32'hF);
    check("whold_addr", ram_addr, 32'h30);
    check("whold_din", ram_data_in, 32'h12345678);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ack", {30'b0, m1_ack, m0_ack}, 32'h0);
    check("abort_ram_ctl", {26'b0, ram_en, ram_write_en, ram_write_sel}, 32'h0);
    check("abort_ram_addr", ram_addr, 32'h0);
    check("abort_ram_din", ram_data_in, 32'h0);
    m0_req = 1'b0;
    rst    = 1'b0;
    @(negedge clk);
    check("abort_no_late_ack", {31'b0, m0_ack}, 32'h0);
    do_req(1'b0, 1'b0, 4'h0, 32'h20, 32'h0, rd0, er0, cy0);
    check("post_rst_lat", cy0, 3);
    check("post_rst_data", rd0, 32'hAABB3344);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
